// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Produces the registered fetch address. It advances sequentially, takes
// prioritised redirects (exception > ERET > branch) and holds while any
// stall source is active. A redirect that arrives during a stall is parked
// in a pending register. It is applied when the stall releases, unless a
// newer redirect of equal or higher priority arrives first.
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'hBFC00000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'hBFC00380),
    parameter int                NUM_STALL = 4,
    parameter int                INC       = 4,
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_STALL-1:0] stall_vec,
    input  logic                 fetch_ready,
    input  logic                 exc_req,
    input  logic                 eret_req,
    input  logic [ADDR_W-1:0]    epc,
    input  logic                 br_valid,
    input  logic [ADDR_W-1:0]    br_target,
    output logic [ADDR_W-1:0]    pc,
    output logic                 pc_valid,
    output logic                 pc_misalign,
    output logic                 redirect_pending,
    output logic [NUM_STALL-1:0] hold_src,
    output logic [CNT_W-1:0]     stall_cnt
);

    // Two-state sequencer: RUN fetches normally; HOLD owns a parked redirect.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Redirect priority codes; a larger value means a higher priority.
    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_BR   = 2'd1;
    localparam logic [1:0] CODE_ERET = 2'd2;
    localparam logic [1:0] CODE_EXC  = 2'd3;

    localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [0:0]           state_r;
    logic [ADDR_W-1:0]    pc_r;
    logic [1:0]           pend_code_r;
    logic [ADDR_W-1:0]    pend_tgt_r;
    logic [NUM_STALL-1:0] hold_src_r;
    logic [CNT_W-1:0]     stall_cnt_r;

    // Next-state values and decoded request information
    logic                 stall_s;
    logic [1:0]           code_s;
    logic [ADDR_W-1:0]    target_s;
    logic                 new_wins_s;
    logic [0:0]           state_nxt_s;
    logic [ADDR_W-1:0]    pc_nxt_s;
    logic [1:0]           pend_code_nxt_s;
    logic [ADDR_W-1:0]    pend_tgt_nxt_s;
    logic [NUM_STALL-1:0] hold_src_nxt_s;

    // Any stall source, or instruction memory not accepting, freezes the PC.
    assign stall_s = (|stall_vec) | ~fetch_ready;

    // Select the highest-priority redirect and its target.
    always_comb begin
        code_s   = CODE_NONE;
        target_s = {ADDR_W{1'b0}};
        if (exc_req) begin
            code_s   = CODE_EXC;
            target_s = EXC_VEC;
        end else if (eret_req) begin
            code_s   = CODE_ERET;
            target_s = epc;
        end else if (br_valid) begin
            code_s   = CODE_BR;
            target_s = br_target;
        end else begin
            code_s   = CODE_NONE;
            target_s = {ADDR_W{1'b0}};
        end
    end

    // A live redirect may supersede the parked one only if it is at least as urgent.
    assign new_wins_s = (code_s != CODE_NONE) && (code_s >= pend_code_r);

    // Next-state logic for the PC, the sequencer and the pending redirect.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        pend_code_nxt_s = pend_code_r;
        pend_tgt_nxt_s  = pend_tgt_r;
        hold_src_nxt_s  = hold_src_r;
        case (state_r)
            ST_RUN: begin
                if (!stall_s) begin
                    if (code_s != CODE_NONE) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = pc_r + INC_V;
                    end
                end else if (code_s != CODE_NONE) begin
                    // Park the redirect; the PC stays put until the stall clears.
                    pend_code_nxt_s = code_s;
                    pend_tgt_nxt_s  = target_s;
                    hold_src_nxt_s  = stall_vec;
                    state_nxt_s     = ST_HOLD;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_HOLD: begin
                if (stall_s) begin
                    hold_src_nxt_s = hold_src_r | stall_vec;
                    if (new_wins_s) begin
                        pend_code_nxt_s = code_s;
                        pend_tgt_nxt_s  = target_s;
                    end else begin
                        pend_code_nxt_s = pend_code_r;
                        pend_tgt_nxt_s  = pend_tgt_r;
                    end
                end else begin
                    if (new_wins_s) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = pend_tgt_r;
                    end
                    pend_code_nxt_s = CODE_NONE;
                    pend_tgt_nxt_s  = {ADDR_W{1'b0}};
                    hold_src_nxt_s  = {NUM_STALL{1'b0}};
                    state_nxt_s     = ST_RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean RUN state.
                state_nxt_s     = ST_RUN;
                pend_code_nxt_s = CODE_NONE;
                pend_tgt_nxt_s  = {ADDR_W{1'b0}};
                hold_src_nxt_s  = {NUM_STALL{1'b0}};
            end
        endcase
    end

    // Register the PC, the sequencer and the pending redirect; reset discards any parked redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pc_r        <= RESET_VEC;
            pend_code_r <= CODE_NONE;
            pend_tgt_r  <= {ADDR_W{1'b0}};
            hold_src_r  <= {NUM_STALL{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            pend_code_r <= pend_code_nxt_s;
            pend_tgt_r  <= pend_tgt_nxt_s;
            hold_src_r  <= hold_src_nxt_s;
        end
    end

    // Count stalled cycles; saturate at all-ones and clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc               = pc_r;
    assign redirect_pending = (state_r == ST_HOLD);
    // The held PC in HOLD is wrong-path, and nothing is valid while reset is applied.
    assign pc_valid         = ~rst & ~redirect_pending;
    // Targets are not realigned, so misalignment is flagged rather than fixed.
    assign pc_misalign      = |pc_r[1:0];
    assign hold_src         = hold_src_r;
    assign stall_cnt        = stall_cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a behavioural reference model.
module tb_pc_gen;

    localparam logic [31:0] RESET_VEC = 32'hBFC00000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam int          CNT_MAX   = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall_vec;
    logic        fetch_ready;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_misalign;
    logic        redirect_pending;
    logic [3:0]  hold_src;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_parked;
    int          m_prio;
    logic [31:0] m_ptgt;
    logic [3:0]  m_src;
    int          m_cnt;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_vec(stall_vec), .fetch_ready(fetch_ready),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .br_valid(br_valid), .br_target(br_target),
        .pc(pc), .pc_valid(pc_valid), .pc_misalign(pc_misalign),
        .redirect_pending(redirect_pending), .hold_src(hold_src), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int prio_of(bit e, bit r, bit b);
        return e ? 3 : (r ? 2 : (b ? 1 : 0));
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit          st;
        int          p;
        logic [31:0] t;
        if (rst) begin
            m_pc = RESET_VEC; m_parked = 0; m_prio = 0; m_ptgt = 32'h0; m_src = 4'h0; m_cnt = 0;
        end else begin
            st = (stall_vec != 4'h0) || !fetch_ready;
            p  = prio_of(exc_req, eret_req, br_valid);
            t  = (p == 3) ? EXC_VEC : (p == 2) ? epc : br_target;
            if (st) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (!m_parked) begin
                if (!st) m_pc = (p != 0) ? t : m_pc + 32'd4;
                else if (p != 0) begin
                    m_parked = 1; m_prio = p; m_ptgt = t; m_src = stall_vec;
                end
            end else if (st) begin
                m_src = m_src | stall_vec;
                if (p != 0 && p >= m_prio) begin m_prio = p; m_ptgt = t; end
            end else begin
                m_pc = (p != 0 && p >= m_prio) ? t : m_ptgt;
                m_parked = 0; m_prio = 0; m_src = 4'h0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", {32'h0, pc}, {32'h0, m_pc});
        chk("pc_valid", {63'h0, pc_valid}, {63'h0, (!rst && !m_parked)});
        chk("pc_misalign", {63'h0, pc_misalign}, {63'h0, (m_pc[1:0] != 2'b00)});
        chk("redirect_pending", {63'h0, redirect_pending}, {63'h0, m_parked});
        chk("hold_src", {60'h0, hold_src}, {60'h0, m_src});
        chk("stall_cnt", {48'h0, stall_cnt}, 64'(m_cnt));
    endtask

    // Apply one cycle of inputs, clock it, update the model, then compare 1 time unit after the edge.
    task automatic cyc(input bit r, input logic [3:0] sv, input bit fr, input bit e,
                       input bit er, input logic [31:0] ep, input bit b, input logic [31:0] bt);
        rst = r; stall_vec = sv; fetch_ready = fr; exc_req = e;
        eret_req = er; epc = ep; br_valid = b; br_target = bt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        m_pc = 32'h0; m_parked = 0; m_prio = 0; m_ptgt = 32'h0; m_src = 4'h0; m_cnt = 0;

        // Reset, then sequential fetch
        cyc(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("reset_pc", {32'h0, pc}, {32'h0, 32'hBFC00000});
        chk("reset_cnt", {48'h0, stall_cnt}, 64'h0);
        idle(); idle(); idle();
        chk("seq_pc", {32'h0, pc}, {32'h0, 32'hBFC0000C});
        chk("seq_valid", {63'h0, pc_valid}, 64'h1);
        idle();

        // Branch during a two-cycle stall
        cyc(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00100);
        chk("stall_hold_pc", {32'h0, pc}, {32'h0, 32'hBFC00010});
        chk("stall_src1", {60'h0, hold_src}, {60'h0, 4'b0010});
        cyc(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_src2", {60'h0, hold_src}, {60'h0, 4'b1010});
        idle();
        chk("release_pc", {32'h0, pc}, {32'h0, 32'hBFC00100});
        chk("release_cnt", {48'h0, stall_cnt}, 64'd2);

        // Pending branch overwritten by an exception
        cyc(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000040);
        cyc(1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        chk("exc_over_br", {32'h0, pc}, {32'h0, 32'hBFC00380});
        // Pending exception not overwritten by a branch
        cyc(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000040);
        idle();
        chk("br_not_over_exc", {32'h0, pc}, {32'h0, 32'hBFC00380});

        // ERET while instruction memory is not ready
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h80001234, 1'b0, 32'h0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        chk("eret_pc", {32'h0, pc}, {32'h0, 32'h80001234});
        chk("eret_aligned", {63'h0, pc_misalign}, 64'h0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h80001236, 1'b0, 32'h0);
        idle();
        chk("eret_misalign", {63'h0, pc_misalign}, 64'h1);

        // Wrap-around of the sequential increment
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
        idle();
        chk("wrap_pc", {32'h0, pc}, {32'h0, 32'h00000000});

        // Reset while holding a pending branch
        cyc(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000040);
        cyc(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000080);
        chk("rst_hold_pc", {32'h0, pc}, {32'h0, 32'hBFC00000});
        chk("rst_hold_pend", {63'h0, redirect_pending}, 64'h0);
        chk("rst_hold_cnt", {48'h0, stall_cnt}, 64'h0);

        // Saturation of the stall counter
        for (int i = 0; i < 65536 + 5; i++) begin
            cyc(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        chk("cnt_saturate", {48'h0, stall_cnt}, {48'h0, 16'hFFFF});
        idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  sv;
            logic [31:0] ep;
            logic [31:0] bt;
            sv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            ep = $urandom;
            bt = $urandom;
            cyc(($urandom_range(0, 63) == 0), sv, ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), ep,
                ($urandom_range(0, 2) == 0), bt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
